ex_mem_stage: RTL and testbench

EX_MEM_STAGE -- requirements
Module: ex_mem_stage

---
 rtl/ex_mem_stage.sv | 136 +++++++++++++
 tb/tb_ex_mem_stage.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage.sv
// ex_mem_stage -- EX/MEM pipeline register with flag register and branch resolution.
//
// Registers the execute-stage result, store data, branch target, destination
// register and memory/writeback control for the memory stage. It also holds the
// architectural NZCV register and resolves CBZ/CBNZ/B.cond into a registered
// branch_taken.
//
// Ports
//   clk, reset_n          clock (rising edge), synchronous active-low reset
//   stall, flush          hold all state / kill the incoming instruction (flush wins)
//   in_valid              execute stage holds a real instruction
//   alu_result            ALU result (WIDTH)
//   negative/zero/overflow/carry_out, set_flags   ALU flags and NZCV write enable
//   store_data, rd        STUR data (WIDTH), destination register (REGW)
//   reg_write, mem_read, mem_write                control for later stages
//   is_bcond, cond, is_cbz, is_cbnz, branch_target branch information
//   out_*                 registered copies; control bits gated by validity
//   branch_taken          registered branch decision
//   flags_q               NZCV register, bit 3 = N ... bit 0 = V
//
// Configuration
//   EX_MEM_COND_EXT_EN    when defined, decode every condition code; otherwise
//                         only EQ, NE, GE and LT are decoded and any other code
//                         never takes the branch.
module ex_mem_stage #(
    parameter int WIDTH = 64,
    parameter int REGW  = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             stall,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             negative,
    input  logic             zero,
    input  logic             overflow,
    input  logic             carry_out,
    input  logic             set_flags,
    input  logic [WIDTH-1:0] store_data,
    input  logic [REGW-1:0]  rd,
    input  logic             reg_write,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic             is_bcond,
    input  logic [3:0]       cond,
    input  logic             is_cbz,
    input  logic             is_cbnz,
    input  logic [WIDTH-1:0] branch_target,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_result,
    output logic [WIDTH-1:0] out_store_data,
    output logic [WIDTH-1:0] out_branch_target,
    output logic [REGW-1:0]  out_rd,
    output logic             out_reg_write,
    output logic             out_mem_read,
    output logic             out_mem_write,
    output logic             branch_taken,
    output logic [3:0]       flags_q
);

    logic flagN, flagZ, flagC, flagV;
    logic condTrue;
    logic takeNext;

    // B.cond looks at the architectural flags, never this cycle's ALU flags.
    assign flagN = flags_q[3];
    assign flagZ = flags_q[2];
    assign flagC = flags_q[1];
    assign flagV = flags_q[0];

    always_comb begin
        condTrue = 1'b0;
        unique case (cond)
            4'h0: condTrue = flagZ;
            4'h1: condTrue = !flagZ;
`ifdef EX_MEM_COND_EXT_EN
            4'h2: condTrue = flagC;
            4'h3: condTrue = !flagC;
            4'h4: condTrue = flagN;
            4'h5: condTrue = !flagN;
            4'h6: condTrue = flagV;
            4'h7: condTrue = !flagV;
            4'h8: condTrue = flagC && !flagZ;
            4'h9: condTrue = !(flagC && !flagZ);
            4'hC: condTrue = !flagZ && (flagN == flagV);
            4'hD: condTrue = !(!flagZ && (flagN == flagV));
            4'hE: condTrue = 1'b1;
            4'hF: condTrue = 1'b1;
`endif
            4'hA: condTrue = (flagN == flagV);
            4'hB: condTrue = (flagN != flagV);
            default: condTrue = 1'b0;
        endcase
    end

    // Several branch kinds at once simply OR their decisions.
    assign takeNext = in_valid && ((is_cbz && zero) ||
                                   (is_cbnz && !zero) ||
                                   (is_bcond && condTrue));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid         <= 1'b0;
            out_result        <= '0;
            out_store_data    <= '0;
            out_branch_target <= '0;
            out_rd            <= '0;
            out_reg_write     <= 1'b0;
            out_mem_read      <= 1'b0;
            out_mem_write     <= 1'b0;
            branch_taken      <= 1'b0;
            flags_q           <= 4'b0000;
        end else if (flush) begin
            // Bubble: kill validity and side effects, keep data and flags.
            out_valid     <= 1'b0;
            out_reg_write <= 1'b0;
            out_mem_read  <= 1'b0;
            out_mem_write <= 1'b0;
            branch_taken  <= 1'b0;
        end else if (!stall) begin
            out_valid         <= in_valid;
            out_result        <= alu_result;
            out_store_data    <= store_data;
            out_branch_target <= branch_target;
            out_rd            <= rd;
            out_reg_write     <= in_valid && reg_write;
            out_mem_read      <= in_valid && mem_read;
            out_mem_write     <= in_valid && mem_write;
            branch_taken      <= takeNext;
            if (in_valid && set_flags)
                flags_q <= {negative, zero, carry_out, overflow};
        end
    end

endmodule

// File: tb/tb_ex_mem_stage.sv
module tb_ex_mem_stage;

    localparam int WIDTH = 64;
    localparam int REGW  = 5;

    logic             clk = 1'b0;
    logic             reset_n, stall, flush, in_valid;
    logic [WIDTH-1:0] alu_result, store_data, branch_target;
    logic             negative, zero, overflow, carry_out, set_flags;
    logic [REGW-1:0]  rd;
    logic             reg_write, mem_read, mem_write;
    logic             is_bcond, is_cbz, is_cbnz;
    logic [3:0]       cond;
    logic             out_valid, out_reg_write, out_mem_read, out_mem_write, branch_taken;
    logic [WIDTH-1:0] out_result, out_store_data, out_branch_target;
    logic [REGW-1:0]  out_rd;
    logic [3:0]       flags_q;

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] result;
        logic [WIDTH-1:0] storeData;
        logic [WIDTH-1:0] target;
        logic [REGW-1:0]  rd;
        logic             rw, mr, mw, bt;
        logic [3:0]       flags;
    } exp_t;

    exp_t mdl = '0;
    exp_t sb[$];
    exp_t got, want;
    int   checks = 0;
    int   errors = 0;

`ifdef EX_MEM_COND_EXT_EN
    localparam logic HI_EXPECT = 1'b1;
`else
    localparam logic HI_EXPECT = 1'b0;
`endif

    ex_mem_stage #(.WIDTH(WIDTH), .REGW(REGW)) dut (
        .clk(clk), .reset_n(reset_n), .stall(stall), .flush(flush),
        .in_valid(in_valid), .alu_result(alu_result),
        .negative(negative), .zero(zero), .overflow(overflow), .carry_out(carry_out),
        .set_flags(set_flags), .store_data(store_data), .rd(rd),
        .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
        .is_bcond(is_bcond), .cond(cond), .is_cbz(is_cbz), .is_cbnz(is_cbnz),
        .branch_target(branch_target),
        .out_valid(out_valid), .out_result(out_result), .out_store_data(out_store_data),
        .out_branch_target(out_branch_target), .out_rd(out_rd),
        .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
        .out_mem_write(out_mem_write), .branch_taken(branch_taken), .flags_q(flags_q)
    );

    always #5 clk = ~clk;

    // ARM-style reference: pairs of codes share a base test, odd codes invert.
    function automatic logic condModel(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, base;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
`ifndef EX_MEM_COND_EXT_EN
        if (!(c == 4'h0 || c == 4'h1 || c == 4'hA || c == 4'hB)) return 1'b0;
`endif
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy & ~z;
            3'd5: base = (n == v);
            3'd6: base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        if (c[0] && c != 4'hF) base = ~base;
        return base;
    endfunction

    function automatic exp_t observed();
        return {out_valid, out_result, out_store_data, out_branch_target, out_rd,
                out_reg_write, out_mem_read, out_mem_write, branch_taken, flags_q};
    endfunction

    task automatic clearIn();
        reset_n = 1'b1; stall = 1'b0; flush = 1'b0; in_valid = 1'b0;
        alu_result = '0; store_data = '0; branch_target = '0; rd = '0;
        negative = 1'b0; zero = 1'b0; overflow = 1'b0; carry_out = 1'b0;
        set_flags = 1'b0; reg_write = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        is_bcond = 1'b0; is_cbz = 1'b0; is_cbnz = 1'b0; cond = 4'h0;
    endtask

    // Predict the next register contents from the current inputs, push it,
    // then advance one edge and settle.
    task automatic tick();
        exp_t nx;
        nx = mdl;
        if (!reset_n) nx = '0;
        else if (flush) begin
            nx.valid = 1'b0; nx.rw = 1'b0; nx.mr = 1'b0; nx.mw = 1'b0; nx.bt = 1'b0;
        end else if (!stall) begin
            nx.valid     = in_valid;
            nx.result    = alu_result;
            nx.storeData = store_data;
            nx.target    = branch_target;
            nx.rd        = rd;
            nx.rw        = in_valid & reg_write;
            nx.mr        = in_valid & mem_read;
            nx.mw        = in_valid & mem_write;
            nx.bt        = in_valid & ((is_cbz & zero) | (is_cbnz & ~zero) |
                                       (is_bcond & condModel(cond, mdl.flags)));
            if (in_valid && set_flags) nx.flags = {negative, zero, carry_out, overflow};
        end
        sb.push_back(nx);
        mdl = nx;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clearIn();
        reset_n = 1'b0; in_valid = 1'b1; alu_result = 64'h5; reg_write = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            got = observed(); want = sb.pop_front(); checks++;
            if (got !== want) begin errors++; $display("FAIL reset_sb got=%h want=%h", got, want); end
        end
        checks++;
        if (out_result !== 64'h0 || out_valid !== 1'b0 || flags_q !== 4'b0000 || branch_taken !== 1'b0) begin
            errors++; $display("FAIL reset_zero result=%h valid=%b flags=%b bt=%b want 0", out_result, out_valid, flags_q, branch_taken);
        end
    endtask

    task automatic test_subs_blt();
        clearIn();
        in_valid = 1'b1; alu_result = 64'hFFFF_FFFF_FFFF_FFFF; negative = 1'b1;
        set_flags = 1'b1; reg_write = 1'b1; rd = 5'd3;
        tick();
        got = observed(); want = sb.pop_front(); checks++;
        if (got !== want) begin errors++; $display("FAIL subs_sb got=%h want=%h", got, want); end
        checks++;
        if (flags_q !== 4'b1000) begin errors++; $display("FAIL subs_flags got=%b want=1000", flags_q); end
        clearIn();
        in_valid = 1'b1; is_bcond = 1'b1; cond = 4'hB; branch_target = 64'h400;
        tick();
        got = observed(); want = sb.pop_front(); checks++;
        if (got !== want) begin errors++; $display("FAIL blt_sb got=%h want=%h", got, want); end
        checks++;
        if (branch_taken !== 1'b1) begin errors++; $display("FAIL blt_taken got=%b want=1", branch_taken); end
    endtask

    task automatic test_stall_flush();
        clearIn();
        in_valid = 1'b1; alu_result = 64'hA5; reg_write = 1'b1; rd = 5'd7;
        tick();
        got = observed(); want = sb.pop_front(); checks++;
        if (got !== want) begin errors++; $display("FAIL load_a5 got=%h want=%h", got, want); end
        stall = 1'b1; alu_result = 64'hFF; set_flags = 1'b1; carry_out = 1'b1; zero = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            got = observed(); want = sb.pop_front(); checks++;
            if (got !== want) begin errors++; $display("FAIL stall_sb got=%h want=%h", got, want); end
        end
        checks++;
        if (out_result !== 64'hA5 || flags_q !== 4'b1000 || out_valid !== 1'b1) begin
            errors++; $display("FAIL stall_hold result=%h flags=%b valid=%b want a5 1000 1", out_result, flags_q, out_valid);
        end
        flush = 1'b1;
        tick();
        got = observed(); want = sb.pop_front(); checks++;
        if (got !== want) begin errors++; $display("FAIL flush_sb got=%h want=%h", got, want); end
        checks++;
        if (out_valid !== 1'b0 || out_reg_write !== 1'b0 || out_result !== 64'hA5 || flags_q !== 4'b1000) begin
            errors++; $display("FAIL flush_kill valid=%b rw=%b result=%h flags=%b want 0 0 a5 1000", out_valid, out_reg_write, out_result, flags_q);
        end
    endtask

    task automatic test_cbz();
        logic [5:0] vec [4];
        logic       btWant [4];
        // {in_valid, is_cbz, is_cbnz, zero, -, -}
        vec[0] = 6'b110100; btWant[0] = 1'b1;
        vec[1] = 6'b101100; btWant[1] = 1'b0;
        vec[2] = 6'b010100; btWant[2] = 1'b0;
        vec[3] = 6'b001000; btWant[3] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            clearIn();
            {in_valid, is_cbz, is_cbnz, zero} = vec[i][5:2];
            branch_target = 64'h1000 + 64'(i);
            tick();
            got = observed(); want = sb.pop_front(); checks++;
            if (got !== want) begin errors++; $display("FAIL cb_sb%0d got=%h want=%h", i, got, want); end
            checks++;
            if (branch_taken !== btWant[i] || out_valid !== vec[i][5]) begin
                errors++; $display("FAIL cb_taken%0d bt=%b valid=%b want %b %b", i, branch_taken, out_valid, btWant[i], vec[i][5]);
            end
        end
    endtask

    task automatic test_flag_hold();
        clearIn();
        in_valid = 1'b1; set_flags = 1'b1; carry_out = 1'b1;
        tick();
        got = observed(); want = sb.pop_front(); checks++;
        if (got !== want) begin errors++; $display("FAIL setc_sb got=%h want=%h", got, want); end
        clearIn();
        in_valid = 1'b1; zero = 1'b1; reg_write = 1'b1; alu_result = 64'h0;
        tick();
        got = observed(); want = sb.pop_front(); checks++;
        if (got !== want) begin errors++; $display("FAIL add_sb got=%h want=%h", got, want); end
        checks++;
        if (flags_q !== 4'b0010) begin errors++; $display("FAIL flag_hold got=%b want=0010", flags_q); end
        clearIn();
        in_valid = 1'b1; is_bcond = 1'b1; cond = 4'h8;
        tick();
        got = observed(); want = sb.pop_front(); checks++;
        if (got !== want) begin errors++; $display("FAIL bhi_sb got=%h want=%h", got, want); end
        checks++;
        if (branch_taken !== HI_EXPECT) begin errors++; $display("FAIL bhi_taken got=%b want=%b", branch_taken, HI_EXPECT); end
    endtask

    task automatic test_reset_mid_stall();
        clearIn();
        in_valid = 1'b1; alu_result = 64'h77; mem_write = 1'b1;
        tick();
        got = observed(); want = sb.pop_front(); checks++;
        if (got !== want) begin errors++; $display("FAIL prestall_sb got=%h want=%h", got, want); end
        stall = 1'b1; reset_n = 1'b0;
        tick();
        got = observed(); want = sb.pop_front(); checks++;
        if (got !== want || out_result !== 64'h0) begin errors++; $display("FAIL rst_stall got=%h want=%h", got, want); end
        stall = 1'b0; reset_n = 1'b1; alu_result = 64'h99;
        tick();
        got = observed(); want = sb.pop_front(); checks++;
        if (got !== want || out_result !== 64'h99 || out_mem_write !== 1'b1) begin
            errors++; $display("FAIL post_rst_load got=%h want=%h", got, want);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 200; i++) begin
            clearIn();
            reset_n    = ($urandom_range(0, 39) != 0);
            stall      = ($urandom_range(0, 5) == 0);
            flush      = ($urandom_range(0, 7) == 0);
            in_valid   = ($urandom_range(0, 3) != 0);
            alu_result = {$urandom, $urandom};
            store_data = {$urandom, $urandom};
            branch_target = {$urandom, $urandom};
            rd         = REGW'($urandom);
            {negative, zero, overflow, carry_out} = 4'($urandom);
            {reg_write, mem_read, mem_write} = 3'($urandom);
            set_flags  = $urandom_range(0, 1);
            cond       = 4'($urandom);
            is_bcond   = set_flags ? 1'b0 : 1'($urandom);
            is_cbz     = ($urandom_range(0, 3) == 0);
            is_cbnz    = ($urandom_range(0, 3) == 0);
            tick();
            got = observed(); want = sb.pop_front(); checks++;
            if (got !== want) begin errors++; $display("FAIL b2b_%0d got=%h want=%h", i, got, want); end
        end
    endtask

    initial begin
        clearIn();
        test_reset();
        test_subs_blt();
        test_stall_flush();
        test_cbz();
        test_flag_hold();
        test_reset_mid_stall();
        test_back_to_back();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL sb_drain left=%0d want=0", sb.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
